boot_loader: RTL

- Upstream loader stage for the single-cycle MIPS `cpu`.
- Receives a byte stream that holds a program image and packs it into 32-bit instruction words.
- Writes each word through the instruction memory write port, holding the CPU in reset the whole time.
- Once the last word is written, releases the CPU to run from PC 0. This replaces testbench backdoor loading of `instruction_memory.data`.

---
 rtl/boot_loader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/boot_loader.sv
// Byte-stream program loader: packs a big-endian image into 32-bit words,
// writes them into instruction memory, then releases the CPU from reset.
module boot_loader #(
  parameter int ADDR_WIDTH     = 8,
  parameter int MAX_WORDS      = 256,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           word_count
);

  localparam int RW = $clog2(RELEASE_CYCLES + 1);
  localparam logic [RW-1:0] REL_LAST = RW'(RELEASE_CYCLES - 1);
  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_CHECK,
    S_DATA,
    S_WRITE,
    S_RELEASE,
    S_RUN,
    S_ERROR
  } state_e;

  state_e                  state_q, state_d;
  logic [15:0]             wc_q, wc_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [31:0]             asm_q, asm_d;
  logic [RW-1:0]           rel_q, rel_d;

  logic                    in_ready_q, in_ready_d;
  logic                    imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]             imem_wdata_q, imem_wdata_d;
  logic                    cpu_reset_q, cpu_reset_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic accept;
  logic last;

  assign accept = in_valid && in_ready_q;
  assign last   = (16'(idx_q) == wc_q - 16'd1);

  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    rel_d   = rel_q;

    unique case (state_q)
      S_HDR_HI: begin
        if (accept) begin
          wc_d[15:8] = in_data;
          state_d    = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (accept) begin
          wc_d[7:0] = in_data;
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (wc_q == 16'd0 || {1'b0, wc_q} > MAX_N) begin
          state_d = S_ERROR;
        end else begin
          idx_d   = '0;
          cnt_d   = 2'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          asm_d = {asm_q[23:0], in_data};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (last) begin
          rel_d   = '0;
          state_d = S_RELEASE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_DATA;
        end
      end
      S_RELEASE: begin
        if (rel_q == REL_LAST) state_d = S_RUN;
        else rel_d = rel_q + 1'b1;
      end
      S_RUN, S_ERROR: begin
        if (reload) state_d = S_HDR_HI;
      end
      default: state_d = S_HDR_HI;
    endcase

    // Outputs are registered copies of the next-state decode
    in_ready_d   = (state_d == S_HDR_HI) || (state_d == S_HDR_LO) ||
                   (state_d == S_DATA);
    imem_we_d    = (state_d == S_WRITE);
    imem_addr_d  = imem_we_d ? idx_d : '0;
    imem_wdata_d = imem_we_d ? asm_d : 32'd0;
    cpu_reset_d  = (state_d != S_RUN);
    done_d       = (state_d == S_RUN);
    error_d      = (state_d == S_ERROR);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_HDR_HI;
      wc_q         <= 16'd0;
      idx_q        <= '0;
      cnt_q        <= 2'd0;
      asm_q        <= 32'd0;
      rel_q        <= '0;
      in_ready_q   <= 1'b1;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'd0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wc_q         <= wc_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      asm_q        <= asm_d;
      rel_q        <= rel_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = wc_q;

endmodule
